// File: rtl/keypad_code_encoder.sv
// Keypad code encoder: synchronises and debounces 10 key lines, encodes new presses as
// 4-bit codes and queues them in a small FIFO. Define MULTI_PRESS_EN to queue every key of a chord.
//
// Debouncer states:
//   state | meaning
//   IDLE  | synchronised keys match the accepted vector, nothing to time
//   COUNT | candidate vector loaded, timing how long it holds unchanged
module keypad_code_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] keys,
    output logic [3:0] code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic [9:0] held_keys,
    output logic       fifo_full
);

    localparam int         PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int         CNT_W   = PTR_W + 1;
    localparam logic [7:0] DB_LOAD = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } db_state_t;

    logic [9:0] sync1_q;
    logic [9:0] keys_s;

    db_state_t  state_q, state_d;
    logic [9:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] stable_q, stable_d;
    logic       accept;

    logic [9:0] rises_all;
    logic [9:0] rises;
    logic [9:0] pending_q, pending_d;

    logic [3:0] emit_idx;
    logic [9:0] emit_mask;
    logic       push;
    logic       pop;

    logic [3:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [3:0]       code_hold_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            keys_s  <= '0;
        end else begin
            sync1_q <= keys;
            keys_s  <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    // Down-counter loaded with DEBOUNCE_CYCLES-1; acceptance on the edge it is seen at zero
    // with the candidate still held, i.e. DEBOUNCE_CYCLES edges after the load.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (keys_s != stable_q) begin
                    cand_d  = keys_s;
                    cnt_d   = DB_LOAD;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (keys_s != cand_q) begin
                    cand_d = keys_s;
                    cnt_d  = DB_LOAD;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    stable_d = cand_q;
                    accept   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rises_all = accept ? (cand_q & ~stable_q) : '0;

`ifdef MULTI_PRESS_EN
    assign rises = rises_all;
`else
    // Keep only the lowest newly pressed key of the chord.
    assign rises = rises_all & (~rises_all + 10'd1);
`endif

    always_comb begin
        emit_idx  = 4'd0;
        emit_mask = '0;
        for (int i = 9; i >= 0; i--) begin
            if (pending_q[i]) begin
                emit_idx     = 4'(i);
                emit_mask    = '0;
                emit_mask[i] = 1'b1;
            end
        end
    end

    assign push      = (pending_q != '0) && !fifo_full;
    assign pop       = code_valid && code_ready;
    assign pending_d = (pending_q & ~(push ? emit_mask : 10'd0)) | rises;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Storage is not reset; it is only read while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= emit_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            code_hold_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + 1'b1;
                code_hold_q <= mem[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign code_valid = (count_q != '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign code       = code_valid ? mem[rd_ptr_q] : code_hold_q;
    assign held_keys  = stable_q;

endmodule
